gbsha_fir_bist: RTL and testbench

On-chip stimulus generator and response checker for the `gbsha_top` delay-line FIR datapath. It drives the FIR's 6-bit sample input with a deterministic test sequence and receives the FIR's 6-bit output. It checks that output against the same sequence delayed by exactly N_TAPS cycles, then reports pass/fail and a saturating mismatch count. It sits beside the FIR core: `x_out` feeds the FIR's x_in and the FIR's y_out returns on `y_in`.

---
 rtl/gbsha_fir_bist.sv | 134 +++++++++++++
 tb/tb_gbsha_fir_bist.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/gbsha_fir_bist.sv
// Built-in self-test for the gbsha_top delay-line FIR: drives a selectable test sequence
// into the FIR and checks the returned samples against the same sequence delayed by N_TAPS.
module gbsha_fir_bist #(
    parameter int          N_TAPS    = 10,
    parameter int          BW        = 6,
    parameter int          N_SAMPLES = 64,
    parameter logic [7:0]  LFSR_SEED = 8'h01
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1:0]    mode,
    output logic [BW-1:0] x_out,
    input  logic [BW-1:0] y_in,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [7:0]    err_count
);

    localparam int LAST = N_SAMPLES + N_TAPS - 1;
    localparam int CW   = $clog2(LAST + 1) + 1;
    localparam logic [BW-1:0] MAXP = BW'((1 << (BW - 1)) - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] lfsrNext(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Shared by stimulus and reference side so both produce the identical sequence.
    function automatic logic [BW-1:0] sampleOf(input logic [1:0] m, input logic [CW-1:0] idx,
                                               input logic [7:0] lfsr);
        case (m)
            2'd0:    return (idx == '0) ? MAXP : '0;
            2'd1:    return MAXP;
            2'd2:    return BW'(lfsr);
            default: return BW'(idx);
        endcase
    endfunction

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_mode;
    logic [7:0]    r_stimLfsr;
    logic [7:0]    r_refLfsr;
    logic [BW-1:0] r_xOut;
    logic [7:0]    r_errCount;
    logic          r_busy;
    logic          r_done;
    logic          r_pass;

    logic [CW-1:0] w_nextIdx;
    logic [CW-1:0] w_refIdx;
    logic          w_compare;
    logic [BW-1:0] w_expected;
    logic          w_mismatch;
    logic [7:0]    w_errNext;
    logic          w_last;

    // The reference generator only advances once compares begin, so it trails the
    // stimulus by exactly N_TAPS samples without any delay-line storage.
    assign w_nextIdx  = r_cnt + CW'(1);
    assign w_refIdx   = r_cnt - CW'(N_TAPS);
    assign w_compare  = (r_cnt >= CW'(N_TAPS));
    assign w_expected = sampleOf(r_mode, w_refIdx, r_refLfsr);
    assign w_mismatch = w_compare && (y_in != w_expected);
    assign w_errNext  = (w_mismatch && (r_errCount != 8'hFF)) ? r_errCount + 8'd1 : r_errCount;
    assign w_last     = (r_cnt == CW'(LAST));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_mode     <= 2'd0;
            r_stimLfsr <= LFSR_SEED;
            r_refLfsr  <= LFSR_SEED;
            r_xOut     <= '0;
            r_errCount <= 8'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state    <= RUN;
                        r_cnt      <= '0;
                        r_mode     <= mode;
                        r_xOut     <= sampleOf(mode, '0, LFSR_SEED);
                        r_stimLfsr <= lfsrNext(LFSR_SEED);
                        r_refLfsr  <= LFSR_SEED;
                        r_errCount <= 8'd0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                    end
                end
                RUN: begin
                    r_cnt <= w_nextIdx;
                    if (w_nextIdx < CW'(N_SAMPLES)) begin
                        r_xOut     <= sampleOf(r_mode, w_nextIdx, r_stimLfsr);
                        r_stimLfsr <= lfsrNext(r_stimLfsr);
                    end else begin
                        r_xOut <= '0;
                    end
                    if (w_compare) begin
                        r_errCount <= w_errNext;
                        r_refLfsr  <= lfsrNext(r_refLfsr);
                    end
                    if (w_last) begin
                        r_state <= DONE;
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_errNext == 8'd0);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign x_out     = r_xOut;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_gbsha_fir_bist.sv
// Bench for gbsha_fir_bist: a delay-line loop stands in for the FIR, and a monitor checks
// each finished run and the early x_out samples against expectations queued by the stimulus.
module tb_gbsha_fir_bist;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       start2;
    logic [1:0] mode;
    logic [1:0] mode2;
    logic [5:0] x_out;
    logic [5:0] y_in;
    logic [5:0] x_out2;
    logic [5:0] y_in2;
    logic       busy, done, pass;
    logic       busy2, done2, pass2;
    logic [7:0] err_count;
    logic [7:0] err_count2;

    always #5 clk = ~clk;

    gbsha_fir_bist dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .x_out(x_out), .y_in(y_in),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count)
    );

    gbsha_fir_bist #(.N_SAMPLES(300)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .mode(mode2), .x_out(x_out2), .y_in(y_in2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err_count2)
    );

    // Stand-in FIR: a register chain whose tap position sets the loop latency.
    logic [5:0] pipe[16];
    logic [5:0] pipe2[16];
    int         loopDelay = 10;
    logic       loopZero  = 1'b0;

    always @(posedge clk) begin
        pipe[0]  <= x_out;
        pipe2[0] <= x_out2;
        for (int i = 1; i < 16; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe2[i] <= pipe2[i-1];
        end
    end

    always_comb begin
        y_in  = loopZero ? 6'd0 : pipe[loopDelay-1];
        y_in2 = ~pipe2[9];
    end

    typedef struct {
        logic       done;
        logic       pass;
        logic [7:0] err;
        int         cycles;
    } result_t;

    result_t    resQ[$];
    logic [5:0] xQ[$];
    int         checkCount = 0;
    int         passCount  = 0;
    logic       prevBusy   = 1'b0;
    int         busyCycles = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic pushResult(input logic d, input logic p, input logic [7:0] e, input int c);
        result_t r;
        r.done = d; r.pass = p; r.err = e; r.cycles = c;
        resQ.push_back(r);
    endtask

    // Monitor: run starts, early samples and run ends are checked as the DUT presents them.
    always @(negedge clk) begin
        result_t r;
        if (busy === 1'b1 && prevBusy !== 1'b1) begin
            busyCycles = 1;
            checkOutput("run start done", int'(done), 0);
            checkOutput("run start pass", int'(pass), 0);
            checkOutput("run start err_count", int'(err_count), 0);
        end else if (busy === 1'b1) begin
            busyCycles++;
        end
        if (busy === 1'b1 && xQ.size() > 0) begin
            checkOutput("x_out sample", int'(x_out), int'(xQ.pop_front()));
        end
        if (busy !== 1'b1 && prevBusy === 1'b1) begin
            if (resQ.size() == 0) begin
                checkOutput("unexpected run end", 1, 0);
            end else begin
                r = resQ.pop_front();
                checkOutput("end done", int'(done), int'(r.done));
                checkOutput("end pass", int'(pass), int'(r.pass));
                checkOutput("end err_count", int'(err_count), int'(r.err));
                checkOutput("end x_out", int'(x_out), 0);
                checkOutput("run length", busyCycles, r.cycles);
            end
        end
        prevBusy = busy;
    end

    task automatic applyStimulus();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n = 0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, " reached done"}, int'(done === 1'b1), 1);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        reset = 1'b1; start = 1'b0; start2 = 1'b0; mode = 2'd0; mode2 = 2'd2;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset pass", int'(pass), 0);
        checkOutput("reset err_count", int'(err_count), 0);
        checkOutput("reset x_out", int'(x_out), 0);
        reset = 1'b0;

        // PRBS through a correct 10-cycle loop; first samples of LFSR from seed 0x01.
        mode = 2'd2; loopDelay = 10;
        xQ = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd17, 6'd35, 6'd7, 6'd14};
        pushResult(1'b1, 1'b1, 8'd0, 74);
        applyStimulus();
        waitDone("prbs");

        // Impulse through a 9-cycle loop: only the impulse compare misses.
        mode = 2'd0; loopDelay = 9;
        pushResult(1'b1, 1'b0, 8'd1, 74);
        applyStimulus();
        waitDone("impulse short loop");

        // Ramp against a grounded return: only s_0 = 0 matches.
        mode = 2'd3; loopZero = 1'b1;
        xQ = '{6'd0, 6'd1, 6'd2};
        pushResult(1'b1, 1'b0, 8'd63, 74);
        applyStimulus();
        waitDone("ramp zero");
        loopZero = 1'b0;

        // Step run aborted by reset during RUN cycle 20, then a clean run.
        mode = 2'd1; loopDelay = 10;
        pushResult(1'b0, 1'b0, 8'd0, 21);
        applyStimulus();
        repeat (20) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pushResult(1'b1, 1'b1, 8'd0, 74);
        applyStimulus();
        waitDone("step after abort");

        // start held through RUN into DONE: exactly one restart from DONE.
        mode = 2'd0;
        pushResult(1'b1, 1'b1, 8'd0, 74);
        pushResult(1'b1, 1'b1, 8'd0, 74);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1;
        waitDone("held start first");
        @(posedge clk); #1 start = 1'b0;
        checkOutput("held restart done drop", int'(done), 0);
        waitDone("held start second");

        // 300-sample PRBS against an inverted return saturates the error count.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        n = 0;
        while (done2 !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("saturate reached done", int'(done2 === 1'b1), 1);
        checkOutput("saturate err_count", int'(err_count2), 255);
        checkOutput("saturate pass", int'(pass2), 0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", resQ.size() + xQ.size(), 0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
